// File: rtl/vbus_arbiter.sv
// 68k-side memory bus arbiter: shares the MEM_* port between the CPU and the vdp DMA engine.
// DMA ownership changes only between CPU cycles. A watchdog force-completes accesses that MEM_ACK never ends.

module vbus_arbiter_chk (
  input logic clk,
  input logic rst_n,
  input logic cpu_dtack_n,
  input logic vbus_dtack_n,
  input logic vbus_dma_ack,
  input logic mem_sel,
  input logic mem_rnw,
  input logic bus_timeout
);

  a_single_dtack: assert property (@(posedge clk) disable iff (!rst_n)
    !(!cpu_dtack_n && !vbus_dtack_n));

  a_cpu_dtack_not_granted: assert property (@(posedge clk) disable iff (!rst_n)
    !cpu_dtack_n |-> !vbus_dma_ack);

  a_dma_reads_only: assert property (@(posedge clk) disable iff (!rst_n)
    (mem_sel && vbus_dma_ack) |-> mem_rnw);

  a_timeout_completes: assert property (@(posedge clk) disable iff (!rst_n)
    bus_timeout |-> (!cpu_dtack_n || !vbus_dtack_n));

endmodule

module vbus_arbiter #(
  parameter int AW = 23,
  parameter int DW = 16,
  parameter int TIMEOUT = 255,
  parameter logic [DW-1:0] TO_DATA = 16'hFFFF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_sel,
  input  logic [AW-1:0] cpu_a,
  input  logic          cpu_rnw,
  input  logic          cpu_uds_n,
  input  logic          cpu_lds_n,
  input  logic [DW-1:0] cpu_di,
  output logic [DW-1:0] cpu_do,
  output logic          cpu_dtack_n,
  input  logic          vbus_dma_req,
  output logic          vbus_dma_ack,
  input  logic          vbus_sel,
  input  logic [AW-1:0] vbus_addr,
  input  logic          vbus_uds_n,
  input  logic          vbus_lds_n,
  output logic [DW-1:0] vbus_data,
  output logic          vbus_dtack_n,
  output logic          mem_sel,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rnw,
  output logic          mem_uds_n,
  output logic          mem_lds_n,
  output logic [DW-1:0] mem_do,
  input  logic [DW-1:0] mem_di,
  input  logic          mem_ack,
  output logic          bus_timeout
);

  localparam int WDW = (TIMEOUT < 256) ? 8 : $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CPU_ACC = 3'd1,
    CPU_END = 3'd2,
    DMA_OWN = 3'd3,
    DMA_ACC = 3'd4,
    DMA_END = 3'd5
  } state_t;

  state_t         state_r;
  state_t         state_nx;
  logic [WDW-1:0] wdog_r;
  logic           in_acc_s;
  logic           acc_done_s;
  logic           wd_expire_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state decode and access-completion detection (a real ack on the terminal count wins)
  always_comb begin
    state_nx    = state_r;
    in_acc_s    = (state_r == CPU_ACC) || (state_r == DMA_ACC);
    acc_done_s  = 1'b0;
    wd_expire_s = 1'b0;
    if (in_acc_s) begin
      if (mem_ack) begin
        acc_done_s = 1'b1;
      end else if (wdog_r == WD_LAST) begin
        acc_done_s  = 1'b1;
        wd_expire_s = 1'b1;
      end else begin
        acc_done_s = 1'b0;
      end
    end else begin
      acc_done_s = 1'b0;
    end

    case (state_r)
      IDLE: begin
        if (vbus_dma_req) begin
          state_nx = DMA_OWN;
        end else if (cpu_sel) begin
          state_nx = CPU_ACC;
        end else begin
          state_nx = IDLE;
        end
      end
      CPU_ACC: begin
        if (acc_done_s) begin
          state_nx = CPU_END;
        end else begin
          state_nx = CPU_ACC;
        end
      end
      CPU_END: begin
        if (cpu_sel) begin
          state_nx = CPU_END;
        end else begin
          state_nx = IDLE;
        end
      end
      DMA_OWN: begin
        if (!vbus_dma_req) begin
          state_nx = IDLE;
        end else if (vbus_sel) begin
          state_nx = DMA_ACC;
        end else begin
          state_nx = DMA_OWN;
        end
      end
      DMA_ACC: begin
        if (acc_done_s) begin
          state_nx = DMA_END;
        end else begin
          state_nx = DMA_ACC;
        end
      end
      DMA_END: begin
        if (vbus_sel) begin
          state_nx = DMA_END;
        end else begin
          state_nx = DMA_OWN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Watchdog: zero outside an access, counts every access cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_r <= '0;
    end else if (in_acc_s) begin
      wdog_r <= wdog_r + WDW'(1);
    end else begin
      wdog_r <= '0;
    end
  end

  // Registered bus outputs; the MEM_* request is latched once when an access starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_do       <= '0;
      cpu_dtack_n  <= 1'b1;
      vbus_dma_ack <= 1'b0;
      vbus_data    <= '0;
      vbus_dtack_n <= 1'b1;
      mem_sel      <= 1'b0;
      mem_addr     <= '0;
      mem_rnw      <= 1'b1;
      mem_uds_n    <= 1'b1;
      mem_lds_n    <= 1'b1;
      mem_do       <= '0;
      bus_timeout  <= 1'b0;
    end else begin
      bus_timeout <= 1'b0;
      case (state_r)
        IDLE: begin
          if (vbus_dma_req) begin
            vbus_dma_ack <= 1'b1;
          end else if (cpu_sel) begin
            mem_sel   <= 1'b1;
            mem_addr  <= cpu_a;
            mem_rnw   <= cpu_rnw;
            mem_uds_n <= cpu_uds_n;
            mem_lds_n <= cpu_lds_n;
            mem_do    <= cpu_di;
          end
        end
        CPU_ACC: begin
          if (acc_done_s) begin
            mem_sel     <= 1'b0;
            mem_rnw     <= 1'b1;
            mem_uds_n   <= 1'b1;
            mem_lds_n   <= 1'b1;
            cpu_dtack_n <= 1'b0;
            bus_timeout <= wd_expire_s;
            if (mem_rnw) begin
              cpu_do <= wd_expire_s ? TO_DATA : mem_di;
            end
          end
        end
        CPU_END: begin
          if (!cpu_sel) begin
            cpu_dtack_n <= 1'b1;
          end
        end
        DMA_OWN: begin
          if (!vbus_dma_req) begin
            vbus_dma_ack <= 1'b0;
          end else if (vbus_sel) begin
            mem_sel   <= 1'b1;
            mem_addr  <= vbus_addr;
            mem_rnw   <= 1'b1;
            mem_uds_n <= vbus_uds_n;
            mem_lds_n <= vbus_lds_n;
          end
        end
        DMA_ACC: begin
          if (acc_done_s) begin
            mem_sel      <= 1'b0;
            mem_uds_n    <= 1'b1;
            mem_lds_n    <= 1'b1;
            vbus_dtack_n <= 1'b0;
            bus_timeout  <= wd_expire_s;
            vbus_data    <= wd_expire_s ? TO_DATA : mem_di;
          end
        end
        DMA_END: begin
          if (!vbus_sel) begin
            vbus_dtack_n <= 1'b1;
          end
        end
        default: begin
          mem_sel <= 1'b0;
        end
      endcase
    end
  end

  vbus_arbiter_chk u_chk (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_dtack_n  (cpu_dtack_n),
    .vbus_dtack_n (vbus_dtack_n),
    .vbus_dma_ack (vbus_dma_ack),
    .mem_sel      (mem_sel),
    .mem_rnw      (mem_rnw),
    .bus_timeout  (bus_timeout)
  );

endmodule

// File: tb/tb_vbus_arbiter.sv
// Bench for vbus_arbiter: directed bus scenarios plus randomized CPU/DMA traffic against a word-memory model.
// A memory responder answers MEM_* with a programmable ack delay; expectations come from shadow memory and timing rules.
`timescale 1ns/1ps

module tb_vbus_arbiter;

  localparam int AW = 23;
  localparam int DW = 16;
  localparam int TMO = 8;
  localparam int NEVER = 100000;

  logic          clk;
  logic          rst_n;
  logic          cpu_sel;
  logic [AW-1:0] cpu_a;
  logic          cpu_rnw;
  logic          cpu_uds_n;
  logic          cpu_lds_n;
  logic [DW-1:0] cpu_di;
  logic [DW-1:0] cpu_do;
  logic          cpu_dtack_n;
  logic          vbus_dma_req;
  logic          vbus_dma_ack;
  logic          vbus_sel;
  logic [AW-1:0] vbus_addr;
  logic          vbus_uds_n;
  logic          vbus_lds_n;
  logic [DW-1:0] vbus_data;
  logic          vbus_dtack_n;
  logic          mem_sel;
  logic [AW-1:0] mem_addr;
  logic          mem_rnw;
  logic          mem_uds_n;
  logic          mem_lds_n;
  logic [DW-1:0] mem_do;
  logic [DW-1:0] mem_di;
  logic          mem_ack;
  logic          bus_timeout;

  vbus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO), .TO_DATA(16'hFFFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_sel(cpu_sel), .cpu_a(cpu_a), .cpu_rnw(cpu_rnw), .cpu_uds_n(cpu_uds_n),
    .cpu_lds_n(cpu_lds_n), .cpu_di(cpu_di), .cpu_do(cpu_do), .cpu_dtack_n(cpu_dtack_n),
    .vbus_dma_req(vbus_dma_req), .vbus_dma_ack(vbus_dma_ack), .vbus_sel(vbus_sel),
    .vbus_addr(vbus_addr), .vbus_uds_n(vbus_uds_n), .vbus_lds_n(vbus_lds_n),
    .vbus_data(vbus_data), .vbus_dtack_n(vbus_dtack_n),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_rnw(mem_rnw), .mem_uds_n(mem_uds_n),
    .mem_lds_n(mem_lds_n), .mem_do(mem_do), .mem_di(mem_di), .mem_ack(mem_ack),
    .bus_timeout(bus_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_delay = 0;
  logic [DW-1:0] exp_cpu_do = 16'h0000;
  logic [DW-1:0] dev_mem [int];
  logic [DW-1:0] ref_mem [int];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h5A3C;
  endfunction

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    else return init_word(a);
  endfunction

  function automatic logic [DW-1:0] dev_rd(input logic [AW-1:0] a);
    if (dev_mem.exists(int'(a))) return dev_mem[int'(a)];
    else return init_word(a);
  endfunction

  // Byte-lane write: an active-low strobe selects the new byte
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic u_n, input logic l_n);
    return {u_n ? old_w[15:8] : new_w[15:8], l_n ? old_w[7:0] : new_w[7:0]};
  endfunction

  function automatic int pick_dly();
    if ($urandom_range(0, 9) == 0) return NEVER;
    else return int'($urandom_range(0, 4));
  endfunction

  // Memory device: acks ack_delay cycles after it first sees MEM_SEL
  initial begin
    int cnt = 0;
    mem_ack = 1'b0;
    mem_di  = 16'h0000;
    forever begin
      @(posedge clk);
      #2;
      if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (mem_sel) begin
        if (cnt >= ack_delay) begin
          mem_ack = 1'b1;
          if (mem_rnw) mem_di = dev_rd(mem_addr);
          else begin
            mem_di = 16'($urandom);
            dev_mem[int'(mem_addr)] = merge(dev_rd(mem_addr), mem_do, mem_uds_n, mem_lds_n);
          end
          cnt = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cpu_start(input logic [AW-1:0] a, input logic rnw, input logic [1:0] strb,
                           input logic [DW-1:0] d);
    cpu_a = a; cpu_rnw = rnw; cpu_uds_n = strb[1]; cpu_lds_n = strb[0]; cpu_di = d;
    cpu_sel = 1'b1;
  endtask

  // Runs a CPU cycle already presented on cpu_* to completion and release
  task automatic cpu_run(input int dly, input bit check_lat);
    int t = 0;
    bit seen = 1'b0;
    bit grant = 1'b0;
    bit to;
    to = (dly > TMO - 1);
    ack_delay = dly;
    while (cpu_dtack_n !== 1'b0 && t < 60) begin
      tick();
      t++;
      if (vbus_dma_ack) grant = 1'b1;
      if (mem_sel && !seen) begin
        seen = 1'b1;
        if (check_lat) check_val("cpu_sel_lat", t, 1);
        check_val("cpu_mem_addr", mem_addr, cpu_a);
        check_val("cpu_mem_rnw", mem_rnw, cpu_rnw);
        check_val("cpu_mem_strb", {mem_uds_n, mem_lds_n}, {cpu_uds_n, cpu_lds_n});
        if (!cpu_rnw) check_val("cpu_mem_do", mem_do, cpu_di);
      end
    end
    check_val("cpu_dtack", cpu_dtack_n, 0);
    if (check_lat) check_val("cpu_dtack_lat", t, to ? TMO + 1 : dly + 2);
    check_val("cpu_timeout", bus_timeout, to);
    check_val("cpu_sel_drop", mem_sel, 0);
    if (cpu_rnw) exp_cpu_do = to ? 16'hFFFF : ref_rd(cpu_a);
    else if (!to) ref_mem[int'(cpu_a)] = merge(ref_rd(cpu_a), cpu_di, cpu_uds_n, cpu_lds_n);
    check_val("cpu_do", cpu_do, exp_cpu_do);
    check_val("cpu_no_grant", grant, 0);
    tick();
    check_val("cpu_dtack_hold", cpu_dtack_n, 0);
    check_val("cpu_timeout_pulse", bus_timeout, 0);
    cpu_sel = 1'b0;
    tick();
    check_val("cpu_dtack_rel", cpu_dtack_n, 1);
  endtask

  // One DMA read while the bus is owned; optionally drops the request mid-access
  task automatic dma_read(input logic [AW-1:0] a, input int dly, input bit drop_req);
    int t = 0;
    bit seen = 1'b0;
    bit stall_bad = 1'b0;
    bit to;
    to = (dly > TMO - 1);
    ack_delay = dly;
    vbus_addr = a;
    {vbus_uds_n, vbus_lds_n} = 2'($urandom_range(0, 2));
    vbus_sel = 1'b1;
    while (vbus_dtack_n !== 1'b0 && t < 60) begin
      tick();
      t++;
      if (cpu_dtack_n == 1'b0) stall_bad = 1'b1;
      if (mem_sel && !seen) begin
        seen = 1'b1;
        check_val("dma_sel_lat", t, 1);
        check_val("dma_mem_addr", mem_addr, a);
        check_val("dma_mem_rnw", mem_rnw, 1);
        check_val("dma_mem_strb", {mem_uds_n, mem_lds_n}, {vbus_uds_n, vbus_lds_n});
        if (drop_req) vbus_dma_req = 1'b0;
      end
    end
    check_val("dma_dtack", vbus_dtack_n, 0);
    check_val("dma_dtack_lat", t, to ? TMO + 1 : dly + 2);
    check_val("dma_data", vbus_data, to ? 16'hFFFF : ref_rd(a));
    check_val("dma_timeout", bus_timeout, to);
    check_val("dma_ack_held", vbus_dma_ack, 1);
    check_val("dma_cpu_stalled", stall_bad, 0);
    vbus_sel = 1'b0;
    tick();
    check_val("dma_dtack_rel", vbus_dtack_n, 1);
  endtask

  task automatic dma_burst(input logic [AW-1:0] base, input int n, input bit cpu_pend);
    int cd;
    cd = int'($urandom_range(0, 4));
    if (cpu_pend) cpu_start(AW'(32'h100 + $urandom_range(0, 15)), 1'($urandom),
                            2'($urandom_range(0, 2)), 16'($urandom));
    vbus_dma_req = 1'b1;
    tick();
    check_val("burst_grant", vbus_dma_ack, 1);
    check_val("burst_no_cpu_sel", mem_sel, 0);
    if (cpu_pend) begin
      tick();
      check_val("burst_cpu_stall_sel", mem_sel, 0);
      check_val("burst_cpu_stall_dtack", cpu_dtack_n, 1);
    end
    for (int i = 0; i < n; i++) dma_read(base + AW'(i), pick_dly(), 1'b0);
    vbus_dma_req = 1'b0;
    tick();
    check_val("burst_release", vbus_dma_ack, 0);
    if (cpu_pend) cpu_run(cd, 1'b0);
  endtask

  initial begin
    bit grant;
    int t;
    rst_n = 1'b0; cpu_sel = 1'b0; cpu_a = '0; cpu_rnw = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
    cpu_di = '0; vbus_dma_req = 1'b0; vbus_sel = 1'b0; vbus_addr = '0;
    vbus_uds_n = 1'b1; vbus_lds_n = 1'b1;
    repeat (3) tick();
    check_val("rst_cpu_dtack", cpu_dtack_n, 1);
    check_val("rst_vbus_dtack", vbus_dtack_n, 1);
    check_val("rst_dma_ack", vbus_dma_ack, 0);
    check_val("rst_mem_sel", mem_sel, 0);
    check_val("rst_mem_rnw", mem_rnw, 1);
    check_val("rst_mem_strb", {mem_uds_n, mem_lds_n}, 2'b11);
    check_val("rst_cpu_do", cpu_do, 0);
    check_val("rst_vbus_data", vbus_data, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_mem_do", mem_do, 0);
    check_val("rst_timeout", bus_timeout, 0);
    rst_n = 1'b1;
    tick();

    // CPU read with ack three cycles after MEM_SEL
    ref_mem[32'h100] = 16'h1234;
    dev_mem[32'h100] = 16'h1234;
    cpu_start(23'h000100, 1'b1, 2'b00, 16'h0000);
    cpu_run(3, 1'b1);
    check_val("read_0x100", cpu_do, 16'h1234);

    // Simultaneous CPU_SEL and DMA request: DMA first, CPU afterwards
    dma_burst(23'h000300, 1, 1'b1);

    // DMA request during CPU_ACC waits for the CPU cycle to finish
    cpu_start(23'h000104, 1'b1, 2'b00, 16'h0000);
    ack_delay = 3;
    grant = 1'b0;
    tick();
    vbus_dma_req = 1'b1;
    t = 0;
    while (cpu_dtack_n !== 1'b0 && t < 40) begin
      tick();
      t++;
      if (vbus_dma_ack) grant = 1'b1;
    end
    exp_cpu_do = ref_rd(23'h000104);
    check_val("mid_cpu_dtack", cpu_dtack_n, 0);
    check_val("mid_cpu_do", cpu_do, exp_cpu_do);
    tick();
    tick();
    if (vbus_dma_ack) grant = 1'b1;
    check_val("mid_grant_withheld", grant, 0);
    cpu_sel = 1'b0;
    tick();
    check_val("mid_cpu_rel", cpu_dtack_n, 1);
    check_val("mid_idle_no_grant", vbus_dma_ack, 0);
    tick();
    check_val("mid_grant", vbus_dma_ack, 1);
    dma_read(23'h200010, 1, 1'b0);
    vbus_dma_req = 1'b0;
    tick();
    check_val("mid_release", vbus_dma_ack, 0);

    // Four-word DMA burst
    dma_burst(23'h200000, 4, 1'b0);

    // Watchdog boundaries: ack on terminal count, one cycle late, never
    cpu_start(23'h000108, 1'b1, 2'b00, 16'h0000);
    cpu_run(TMO - 1, 1'b1);
    cpu_start(23'h000108, 1'b1, 2'b00, 16'h0000);
    cpu_run(TMO, 1'b1);
    check_val("to_cpu_do", cpu_do, 16'hFFFF);
    cpu_start(23'h00010A, 1'b1, 2'b01, 16'h0000);
    cpu_run(NEVER, 1'b1);

    // DMA request dropped mid-access: access completes, then release
    vbus_dma_req = 1'b1;
    tick();
    check_val("drop_grant", vbus_dma_ack, 1);
    dma_read(23'h200020, 3, 1'b1);
    check_val("drop_ack_to_end", vbus_dma_ack, 1);
    tick();
    check_val("drop_release", vbus_dma_ack, 0);

    // Asynchronous reset in the middle of a DMA access
    vbus_dma_req = 1'b1;
    tick();
    vbus_addr = 23'h200030;
    vbus_sel = 1'b1;
    ack_delay = NEVER;
    tick();
    tick();
    check_val("arst_pre_sel", mem_sel, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_mem_sel", mem_sel, 0);
    check_val("arst_dma_ack", vbus_dma_ack, 0);
    check_val("arst_vbus_dtack", vbus_dtack_n, 1);
    vbus_sel = 1'b0;
    vbus_dma_req = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cpu_do = 16'h0000;
    tick();

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 3) begin
        dma_burst(AW'(32'h100 + $urandom_range(0, 12)), int'($urandom_range(1, 4)), 1'($urandom));
      end else begin
        cpu_start(AW'(32'h100 + $urandom_range(0, 15)), 1'($urandom), 2'($urandom_range(0, 2)),
                  16'($urandom));
        cpu_run(pick_dly(), 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit: got timeout expected completion");
    $fatal(1);
  end

endmodule
